// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding load/store controller around a byte-lane word RAM.
// Loads return the addressed byte/halfword lane, extended to 32 bits.
// Misaligned and illegal-size requests come back as an error without touching the RAM.
// Optional feature macro: LSU_HALFWORD_EN. When undefined, size 01 is treated as illegal.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int Depth = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    capture;
  logic                    reqIllegal;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   mem [Depth];
  logic [DATA_WIDTH-1:0]   rdWord_q;
  logic [3:0]              byteEn;
  logic [DATA_WIDTH-1:0]   wdataLanes;
  logic [7:0]              byteLane;
  logic [DATA_WIDTH-1:0]   loadData;
  logic                    respValid_q;
  logic [DATA_WIDTH-1:0]   respRdata_q;
  logic                    respErr_q;
  logic                    unusedAddrBits;

  // Upper address bits are deliberately ignored so the address space wraps.
  assign unusedAddrBits = ^req_addr[31:ADDR_WIDTH];

  // Classify the incoming request as illegal (bad size or misaligned) before capture.
  always_comb begin
    reqIllegal = 1'b0;
    case (req_size)
      2'b00:   reqIllegal = 1'b0;
`ifdef LSU_HALFWORD_EN
      2'b01:   reqIllegal = req_addr[0];
`else
      2'b01:   reqIllegal = 1'b1;
`endif
      2'b10:   reqIllegal = (req_addr[1:0] != 2'b00);
      default: reqIllegal = 1'b1;
    endcase
  end

  // Next-state logic; ready depends on state alone, so there is no path from req_valid.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          state_d = reqIllegal ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and request capture; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr[ADDR_WIDTH-1:0];
        wdata_q <= req_wdata;
        err_q   <= reqIllegal;
      end
    end
  end

  // Byte enables and lane-replicated store data for the ACCESS cycle.
  always_comb begin
    byteEn     = 4'b0000;
    wdataLanes = wdata_q;
    if (state_q == ACCESS && we_q && !err_q) begin
      case (size_q)
        2'b00: begin
          byteEn     = 4'b0001 << addr_q[1:0];
          wdataLanes = {4{wdata_q[7:0]}};
        end
`ifdef LSU_HALFWORD_EN
        2'b01: begin
          byteEn     = addr_q[1] ? 4'b1100 : 4'b0011;
          wdataLanes = {2{wdata_q[15:0]}};
        end
`endif
        2'b10:   byteEn = 4'b1111;
        default: byteEn = 4'b0000;
      endcase
    end
  end

  // RAM port: byte-enabled write for stores, registered word read for loads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) begin
        mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wdataLanes[8*i +: 8];
      end
    end
    if (state_q == ACCESS && !we_q) begin
      rdWord_q <= mem[addr_q[ADDR_WIDTH-1:2]];
    end
  end

  // Select the addressed lane of the read word and extend it to full width.
  always_comb begin
    byteLane = rdWord_q[7:0];
    case (addr_q[1:0])
      2'b00:   byteLane = rdWord_q[7:0];
      2'b01:   byteLane = rdWord_q[15:8];
      2'b10:   byteLane = rdWord_q[23:16];
      default: byteLane = rdWord_q[31:24];
    endcase
    loadData = '0;
    case (size_q)
      2'b00: loadData = {{24{~uns_q & byteLane[7]}}, byteLane};
`ifdef LSU_HALFWORD_EN
      2'b01: begin
        if (addr_q[1]) begin
          loadData = {{16{~uns_q & rdWord_q[31]}}, rdWord_q[31:16]};
        end else begin
          loadData = {{16{~uns_q & rdWord_q[15]}}, rdWord_q[15:0]};
        end
      end
`endif
      2'b10:   loadData = rdWord_q;
      default: loadData = '0;
    endcase
  end

  // Registered one-cycle response; data and error are zero outside the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      respValid_q <= 1'b0;
      respRdata_q <= '0;
      respErr_q   <= 1'b0;
    end else if (state_q == RESP) begin
      respValid_q <= 1'b1;
      respErr_q   <= err_q;
      respRdata_q <= (err_q || we_q) ? '0 : loadData;
    end else begin
      respValid_q <= 1'b0;
      respRdata_q <= '0;
      respErr_q   <= 1'b0;
    end
  end

  assign resp_valid = respValid_q;
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed test of data_mem_ctrl against a byte-level memory model.
// Honours LSU_HALFWORD_EN in the same way as the design.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int testsRun = 0;
   int testsFailed = 0;
   int cycleCnt = 0;

   int          expCycle = -1;
   logic        expErr = 1'b0;
   logic [31:0] expData = 32'd0;
   bit          expDc = 1'b0;
   int          lastRespCycle = -1;
   logic [31:0] lastRdata = 32'd0;
   logic        lastErr = 1'b0;

   logic [7:0] modelMem [4096];
   bit         modelKnown [4096];

   logic [31:0] rd;
   logic        er;
   int          lat;

   data_mem_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   // Free-running clock with a 10-unit period
   always #5 clk = ~clk;

   // Count rising edges so acceptance and response cycles can be related
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Single comparison point used by every check in the bench
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, actual, expected, cycleCnt);
      end
   endtask

   // Apply a request to the byte-level model and derive the expected response
   task automatic modelAccept(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] data, output bit dc,
                              output int latency);
      int base;
      int n;
      bit halfOk;
      logic [31:0] raw;
`ifdef LSU_HALFWORD_EN
      halfOk = 1'b1;
`else
      halfOk = 1'b0;
`endif
      base = int'(addr % 4096);
      case (size)
         2'b00:   n = 1;
         2'b01:   n = 2;
         2'b10:   n = 4;
         default: n = 0;
      endcase
      err = (n == 0) || (n == 2 && !halfOk) || (n != 0 && (base % n) != 0);
      data = 32'd0;
      dc = 1'b0;
      if (err) begin
         latency = 1;
      end else begin
         latency = 2;
         if (we) begin
            for (int i = 0; i < n; i++) begin
               modelMem[base + i] = 8'((wdata >> (8 * i)) & 32'hFF);
               modelKnown[base + i] = 1'b1;
            end
         end else begin
            raw = 32'd0;
            for (int i = 0; i < n; i++) begin
               raw = raw | (32'(modelMem[base + i]) << (8 * i));
               if (!modelKnown[base + i]) dc = 1'b1;
            end
            if (n < 4 && !uns && raw[8 * n - 1]) raw = raw | (32'hFFFFFFFF << (8 * n));
            data = raw;
         end
      end
   endtask

   // Every cycle: response must match the model exactly on its cycle and be all-zero otherwise
   always @(negedge clk) begin
      if (cycleCnt == expCycle) begin
         checkOutput("respValid", 32'(resp_valid), 32'd1);
         checkOutput("respErr", 32'(resp_err), 32'(expErr));
         if (!expDc) checkOutput("respRdata", resp_rdata, expData);
         lastRdata = resp_rdata;
         lastErr = resp_err;
         lastRespCycle = cycleCnt;
      end else begin
         checkOutput("idleValid", 32'(resp_valid), 32'd0);
         checkOutput("idleRdata", resp_rdata, 32'd0);
         checkOutput("idleErr", 32'(resp_err), 32'd0);
      end
   end

   // Issue one request, wait for its response, and report data, error and latency
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err, output int latency);
      int waitCnt;
      int acceptCycle;
      int modelLat;
      logic mErr;
      logic [31:0] mData;
      bit mDc;
      waitCnt = 0;
      while (!req_ready && waitCnt < 20) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      checkOutput("readyBeforeReq", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we = we;
      req_size = size;
      req_unsigned = uns;
      req_addr = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      acceptCycle = cycleCnt;
      modelAccept(we, size, uns, addr, wdata, mErr, mData, mDc, modelLat);
      expErr = mErr;
      expData = mData;
      expDc = mDc;
      expCycle = acceptCycle + modelLat;
      lastRespCycle = -1;
      req_valid = 1'b0;
      req_wdata = 32'h0BAD0BAD;
      waitCnt = 0;
      while (lastRespCycle < 0 && waitCnt < 10) begin
         @(negedge clk);
         #1;
         waitCnt++;
      end
      checkOutput("respSeen", 32'(lastRespCycle >= 0), 32'd1);
      rdata = lastRdata;
      err = lastErr;
      latency = lastRespCycle - acceptCycle;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         modelMem[i] = 8'h00;
         modelKnown[i] = 1'b0;
      end

      // Reset values
      #12;
      checkOutput("rstReady", 32'(req_ready), 32'd1);
      checkOutput("rstValid", 32'(resp_valid), 32'd0);
      checkOutput("rstRdata", resp_rdata, 32'd0);
      checkOutput("rstErr", 32'(resp_err), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset during the ACCESS cycle of a store
      req_valid = 1'b1;
      req_we = 1'b1;
      req_size = 2'b10;
      req_unsigned = 1'b0;
      req_addr = 32'h40;
      req_wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstReady", 32'(req_ready), 32'd1);
      checkOutput("midRstValid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("postRstReady", 32'(req_ready), 32'd1);
      checkOutput("postRstValid", 32'(resp_valid), 32'd0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
      checkOutput("rstNoWrite", 32'(rd !== 32'hDEADBEEF), 32'd1);

      // Word round trip
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, rd, er, lat);
      checkOutput("storeRdataZero", rd, 32'd0);
      checkOutput("storeLat", 32'(lat), 32'd2);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
      checkOutput("wordLoad", rd, 32'h8899AABB);
      checkOutput("wordErr", 32'(er), 32'd0);
      checkOutput("wordLat", 32'(lat), 32'd2);

      // Byte extension
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat);
      checkOutput("lb11", rd, 32'hFFFFFFAA);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, er, lat);
      checkOutput("lbu11", rd, 32'h000000AA);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat);
      checkOutput("lb13", rd, 32'hFFFFFF88);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lat);
      checkOutput("lb10", rd, 32'hFFFFFFBB);

      // Byte store merge
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234565A, rd, er, lat);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
      checkOutput("sbMerge", rd, 32'h885AAABB);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, rd, er, lat);

`ifdef LSU_HALFWORD_EN
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat);
      checkOutput("lh12", rd, 32'hFFFF885A);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat);
      checkOutput("lhu12", rd, 32'h0000885A);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, er, lat);
      checkOutput("lh11Err", 32'(er), 32'd1);
      checkOutput("lh11Rdata", rd, 32'd0);
      checkOutput("lh11Lat", 32'(lat), 32'd1);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h16, 32'hAAAAAAAA, rd, er, lat);
      checkOutput("sw16Err", 32'(er), 32'd1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
      checkOutput("sw16NoWrite", rd, 32'h11223344);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234BEEF, rd, er, lat);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
      checkOutput("shMerge", rd, 32'hBEEF3344);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, rd, er, lat);
      checkOutput("lh16", rd, 32'hFFFFBEEF);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h17, 32'h00000077, rd, er, lat);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
      checkOutput("sbLane3", rd, 32'h77EF3344);
`else
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat);
      checkOutput("lh10Err", 32'(er), 32'd1);
      checkOutput("lh10Rdata", rd, 32'd0);
      checkOutput("lh10Lat", 32'(lat), 32'd1);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h14, 32'h0000BEEF, rd, er, lat);
      checkOutput("sh14Err", 32'(er), 32'd1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
      checkOutput("sh14NoWrite", rd, 32'h11223344);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h17, 32'h00000077, rd, er, lat);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
      checkOutput("sbLane3", rd, 32'h77223344);
`endif

      // Misaligned word and illegal size
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd, er, lat);
      checkOutput("lw12Err", 32'(er), 32'd1);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat);
      checkOutput("size3Err", 32'(er), 32'd1);
      checkOutput("size3Lat", 32'(lat), 32'd1);
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, rd, er, lat);
      checkOutput("size3StErr", 32'(er), 32'd1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
      checkOutput("size3NoWrite", rd, 32'h885AAABB);

      // Address wrap-around
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, rd, er, lat);
      checkOutput("wrapLoad", rd, 32'h885AAABB);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFFFF020, 32'hCAFEF00D, rd, er, lat);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, rd, er, lat);
      checkOutput("wrapStore", rd, 32'hCAFEF00D);

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
